// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI data path (read side today, write side later).
package sd_pkg;

  // Block reader state machine encoding.
  typedef enum logic [2:0] {
    IDLE,
    WAIT_TOKEN,
    DATA,
    CRC,
    DONE,
    ERR
  } rd_state_t;

  localparam logic [7:0]  SD_TOKEN_START = 8'hFE;
  localparam logic [7:0]  SD_FILL        = 8'hFF;
  localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;

  // One MSB-first step of the CRC16-CCITT shift register.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? SD_CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_block_reader_if.sv
// Handshake and data stream between the SD controller and the block reader.
interface sd_block_reader_if;
  logic        start;
  logic        D0;
  logic        D1;
  logic        active;
  logic [7:0]  data_byte;
  logic        data_valid;
  logic [15:0] byte_index;
  logic        done;
  logic        crc_err;
  logic        tok_err;
  logic        timeout;
  logic [3:0]  err_code;

  // Controller side: requests a read and supplies the card's MISO line.
  modport master (
    output start, D0,
    input  D1, active, data_byte, data_valid, byte_index,
    input  done, crc_err, tok_err, timeout, err_code
  );

  // Reader side.
  modport slave (
    input  start, D0,
    output D1, active, data_byte, data_valid, byte_index,
    output done, crc_err, tok_err, timeout, err_code
  );
endinterface

// File: rtl/sd_crc16.sv
// Bit-serial CRC16-CCITT (poly 0x1021, init 0, MSB first, no reflection, no final XOR).
module sd_crc16
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  // Shift one data bit per enabled cycle; clear restarts the checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_reg <= '0;
    end else if (clear) begin
      crc_reg <= '0;
    end else if (en) begin
      crc_reg <= crc16_step(crc_reg, din);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/sd_block_reader.sv
// SD SPI single-block data phase: waits for the start token, streams BLOCK_BYTES
// bytes out with per-byte valid pulses, then checks the trailing CRC16.
module sd_block_reader
  import sd_pkg::*;
#(
  parameter int BLOCK_BYTES   = 4,
  parameter int TIMEOUT_BYTES = 255
) (
  input  logic               clk,
  input  logic               reset,
  sd_block_reader_if.slave   bus
);

  localparam int SLOT_W = $clog2(TIMEOUT_BYTES + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(TIMEOUT_BYTES - 1);
  localparam logic [15:0]       LAST_INDEX = 16'(BLOCK_BYTES - 1);

  rd_state_t state_reg, state_next;

  // Only the previous seven bits are kept; the eighth is D0 on the completing edge.
  logic [6:0]        shift_reg;
  logic [2:0]        bit_cnt_reg;
  logic [SLOT_W-1:0] slot_cnt_reg;
  logic [15:0]       data_cnt_reg;
  logic [3:0]        crc_cnt_reg;
  logic [14:0]       crc_rx_reg;
  logic [7:0]        data_byte_reg;
  logic              data_valid_reg;
  logic [15:0]       byte_index_reg;
  logic              crc_err_reg;
  logic              tok_err_reg;
  logic              timeout_reg;
  logic [3:0]        err_code_reg;

  logic [7:0]  byte_next;
  logic        byte_done;
  logic [15:0] crc_calc;
  logic        crc_clear;
  logic        crc_en;

  assign byte_next = {shift_reg, bus.D0};
  assign byte_done = (bit_cnt_reg == 3'd7);
  assign crc_clear = (state_reg == IDLE);
  assign crc_en    = (state_reg == DATA) && bus.start;

  sd_crc16 u_crc (
    .clk   (clk),
    .reset (reset),
    .clear (crc_clear),
    .en    (crc_en),
    .din   (bus.D0),
    .crc   (crc_calc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; dropping start aborts any in-progress phase.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) state_next = WAIT_TOKEN;
      end
      WAIT_TOKEN: begin
        if (!bus.start) begin
          state_next = IDLE;
        end else if (byte_done) begin
          if (byte_next == SD_TOKEN_START) begin
            state_next = DATA;
          end else if (byte_next == SD_FILL) begin
            if (slot_cnt_reg == SLOT_LAST) state_next = ERR;
          end else begin
            state_next = ERR;
          end
        end
      end
      DATA: begin
        if (!bus.start) begin
          state_next = IDLE;
        end else if (byte_done && (data_cnt_reg == LAST_INDEX)) begin
          state_next = CRC;
        end
      end
      CRC: begin
        if (!bus.start) begin
          state_next = IDLE;
        end else if (crc_cnt_reg == 4'd15) begin
          state_next = DONE;
        end
      end
      DONE, ERR: begin
        if (!bus.start) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bit sampling, byte assembly, counters and result flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      slot_cnt_reg   <= '0;
      data_cnt_reg   <= '0;
      crc_cnt_reg    <= '0;
      crc_rx_reg     <= '0;
      data_byte_reg  <= '0;
      data_valid_reg <= 1'b0;
      byte_index_reg <= '0;
      crc_err_reg    <= 1'b0;
      tok_err_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      err_code_reg   <= '0;
    end else begin
      data_valid_reg <= 1'b0;
      if (state_reg == IDLE) begin
        // Hold alignment at zero so the first sampled bit after start is bit 7 of a byte.
        shift_reg    <= '0;
        bit_cnt_reg  <= '0;
        slot_cnt_reg <= '0;
        data_cnt_reg <= '0;
        crc_cnt_reg  <= '0;
        crc_rx_reg   <= '0;
        // Results of the previous read stay visible until the next one begins.
        if (bus.start) begin
          byte_index_reg <= '0;
          crc_err_reg    <= 1'b0;
          tok_err_reg    <= 1'b0;
          timeout_reg    <= 1'b0;
          err_code_reg   <= '0;
        end
      end else begin
        shift_reg   <= byte_next[6:0];
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        case (state_reg)
          WAIT_TOKEN: begin
            if (bus.start && byte_done) begin
              if (byte_next == SD_FILL) begin
                slot_cnt_reg <= slot_cnt_reg + SLOT_W'(1);
                if (slot_cnt_reg == SLOT_LAST) timeout_reg <= 1'b1;
              end else if (byte_next != SD_TOKEN_START) begin
                tok_err_reg  <= 1'b1;
                err_code_reg <= (byte_next[7:4] == 4'h0) ? byte_next[3:0] : 4'h0;
              end
            end
          end
          DATA: begin
            if (bus.start && byte_done) begin
              data_byte_reg  <= byte_next;
              data_valid_reg <= 1'b1;
              byte_index_reg <= data_cnt_reg;
              data_cnt_reg   <= data_cnt_reg + 16'd1;
            end
          end
          CRC: begin
            if (bus.start) begin
              crc_rx_reg  <= {crc_rx_reg[13:0], bus.D0};
              crc_cnt_reg <= crc_cnt_reg + 4'd1;
              if (crc_cnt_reg == 4'd15) crc_err_reg <= ({crc_rx_reg, bus.D0} != crc_calc);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.D1         = 1'b1;
  assign bus.active     = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE) || (state_reg == ERR);
  assign bus.data_byte  = data_byte_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.byte_index = byte_index_reg;
  assign bus.crc_err    = crc_err_reg;
  assign bus.tok_err    = tok_err_reg;
  assign bus.timeout    = timeout_reg;
  assign bus.err_code   = err_code_reg;

endmodule

// File: tb/tb_sd_block_reader.sv
// Randomized bench for sd_block_reader with a byte-level reference model.
module tb_sd_block_reader;
  localparam int BB   = 9;
  localparam int TO   = 16;
  localparam int MAXC = 512;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sd_block_reader_if bus();

  sd_block_reader #(.BLOCK_BYTES(BB), .TIMEOUT_BYTES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  stream[$];
  logic [7:0]  rdata[$];
  logic [7:0]  q[$];
  bit          exp_valid[MAXC];
  logic [7:0]  exp_vbyte[MAXC];
  logic [15:0] exp_vidx[MAXC];
  int          end_c, drop_c;
  logic        m_crc_err, m_tok, m_to;
  logic [3:0]  m_code;
  bit          run = 1'b0;
  int          c_now = 0;
  int          obs_nvalid, obs_first_done;
  logic [7:0]  obs_bytes[$];
  int          r_kind, r_slots, r_ab;
  logic [15:0] r_crc;

  task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int k);
    return (k < stream.size()) ? stream[k] : 8'hFF;
  endfunction

  function automatic logic bit_at(input int c);
    logic [7:0] b;
    b = byte_at(c / 8);
    return b[7 - (c % 8)];
  endfunction

  // Byte-wise XMODEM-style CRC over a whole payload.
  function automatic logic [15:0] crc_model(input logic [7:0] d[$]);
    logic [15:0] c;
    c = 16'h0000;
    foreach (d[i]) begin
      c ^= {d[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Cycle c = outputs after the c-th posedge following the edge that saw start in IDLE.
  task automatic build_model(input int abort_at);
    int k, slots, t;
    logic [7:0] b;
    logic [7:0] data[$];
    logic [15:0] rx;
    for (int i = 0; i < MAXC; i++) exp_valid[i] = 1'b0;
    m_crc_err = 1'b0; m_tok = 1'b0; m_to = 1'b0; m_code = 4'h0;
    slots = 0; k = 0;
    while (1'b1) begin
      b = byte_at(k);
      t = 8 * k + 8;
      if (b == 8'hFE) begin
        data.delete();
        for (int j = 0; j < BB; j++) begin
          data.push_back(byte_at(k + 1 + j));
          exp_valid[t + 8 * (j + 1)] = 1'b1;
          exp_vbyte[t + 8 * (j + 1)] = byte_at(k + 1 + j);
          exp_vidx[t + 8 * (j + 1)]  = 16'(j);
        end
        rx = {byte_at(k + BB + 1), byte_at(k + BB + 2)};
        m_crc_err = (rx != crc_model(data));
        end_c = t + 8 * BB + 16;
        break;
      end else if (b == 8'hFF) begin
        slots++;
        if (slots == TO) begin
          m_to = 1'b1;
          end_c = t;
          break;
        end
      end else begin
        m_tok = 1'b1;
        m_code = (b[7:4] == 4'h0) ? b[3:0] : 4'h0;
        end_c = t;
        break;
      end
      k++;
    end
    if (abort_at > 0 && abort_at < end_c) begin
      drop_c = abort_at;
      m_crc_err = 1'b0; m_tok = 1'b0; m_to = 1'b0; m_code = 4'h0;
      for (int i = abort_at; i < MAXC; i++) exp_valid[i] = 1'b0;
    end else begin
      drop_c = end_c + 3;
    end
  endtask

  // Compare DUT against the model on every cycle of a read window.
  always @(posedge clk) begin
    #1;
    if (run) begin
      check("D1", c_now, 32'(bus.D1), 32'd1);
      check("active", c_now, 32'(bus.active), 32'(c_now < drop_c));
      check("done", c_now, 32'(bus.done), 32'(c_now >= end_c && c_now < drop_c));
      check("data_valid", c_now, 32'(bus.data_valid), 32'(exp_valid[c_now]));
      if (exp_valid[c_now]) begin
        check("data_byte", c_now, 32'(bus.data_byte), 32'(exp_vbyte[c_now]));
        check("byte_index", c_now, 32'(bus.byte_index), 32'(exp_vidx[c_now]));
      end
      check("crc_err", c_now, 32'(bus.crc_err), 32'((c_now >= end_c) ? m_crc_err : 1'b0));
      check("tok_err", c_now, 32'(bus.tok_err), 32'((c_now >= end_c) ? m_tok : 1'b0));
      check("timeout", c_now, 32'(bus.timeout), 32'((c_now >= end_c) ? m_to : 1'b0));
      check("err_code", c_now, 32'(bus.err_code), 32'((c_now >= end_c) ? m_code : 4'h0));
      if (bus.data_valid === 1'b1) begin
        obs_nvalid++;
        obs_bytes.push_back(bus.data_byte);
      end
      if (bus.done === 1'b1 && obs_first_done < 0) obs_first_done = c_now;
      c_now++;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_active"}, -1, 32'(bus.active), 32'd0);
    check({tag, "_done"}, -1, 32'(bus.done), 32'd0);
    check({tag, "_valid"}, -1, 32'(bus.data_valid), 32'd0);
    check({tag, "_data_byte"}, -1, 32'(bus.data_byte), 32'd0);
    check({tag, "_byte_index"}, -1, 32'(bus.byte_index), 32'd0);
    check({tag, "_flags"}, -1, 32'({bus.crc_err, bus.tok_err, bus.timeout, bus.err_code}), 32'd0);
    check({tag, "_D1"}, -1, 32'(bus.D1), 32'd1);
  endtask

  task automatic run_read(input int abort_at, input int reset_at);
    build_model(abort_at);
    obs_nvalid = 0;
    obs_first_done = -1;
    obs_bytes.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.D0 = 1'b1;
    c_now = 0;
    run = 1'b1;
    for (int c = 0; c <= drop_c + 2; c++) begin
      @(negedge clk);
      if (c == reset_at) begin
        run = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        bus.D0 = 1'b1;
        repeat (2) @(negedge clk);
        $display("read: reset at cycle %0d", c);
        return;
      end
      if (c + 1 >= drop_c) bus.start = 1'b0;
      bus.D0 = bit_at(c);
    end
    run = 1'b0;
    bus.D0 = 1'b1;
    @(negedge clk);
    $display("read: bytes=%0d end=%0d drop=%0d valids=%0d done_at=%0d crc_err=%b tok_err=%b timeout=%b code=%h",
             stream.size(), end_c, drop_c, obs_nvalid, obs_first_done,
             bus.crc_err, bus.tok_err, bus.timeout, bus.err_code);
  endtask

  task automatic push_block_with_crc();
    foreach (rdata[i]) stream.push_back(rdata[i]);
    r_crc = crc_model(rdata);
    stream.push_back(r_crc[15:8]);
    stream.push_back(r_crc[7:0]);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.D0 = 1'b1;
    #12 check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;

    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_check_value", -1, 32'(crc_model(q)), 32'h31C3);

    // Nominal read
    rdata = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    stream = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
    push_block_with_crc();
    run_read(-1, -1);
    check("nom_nvalid", -1, 32'(obs_nvalid), 32'd9);
    check("nom_byte0", -1, 32'(obs_bytes[0]), 32'hDE);
    check("nom_byte1", -1, 32'(obs_bytes[1]), 32'hAD);
    check("nom_byte2", -1, 32'(obs_bytes[2]), 32'hBE);
    check("nom_byte3", -1, 32'(obs_bytes[3]), 32'hEF);
    check("nom_done_cycle", -1, 32'(obs_first_done), 32'd120);
    check("nom_crc_err", -1, 32'(bus.crc_err), 32'd0);

    // Known-answer CRC, good then off by one
    stream = '{8'hFF, 8'hFE, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
    run_read(-1, -1);
    check("crc_good", -1, 32'(bus.crc_err), 32'd0);
    stream[12] = 8'hC2;
    run_read(-1, -1);
    check("crc_bad", -1, 32'(bus.crc_err), 32'd1);

    // Data-error token
    stream = '{8'hFF, 8'hFF, 8'h08};
    run_read(-1, -1);
    check("errtok_tok_err", -1, 32'(bus.tok_err), 32'd1);
    check("errtok_code", -1, 32'(bus.err_code), 32'h8);
    check("errtok_nvalid", -1, 32'(obs_nvalid), 32'd0);
    check("errtok_done_cycle", -1, 32'(obs_first_done), 32'd24);

    // Timeout: D0 held high
    stream.delete();
    run_read(-1, -1);
    check("timeout_flag", -1, 32'(bus.timeout), 32'd1);
    check("timeout_done_cycle", -1, 32'(obs_first_done), 32'd128);

    // Token in the last permitted slot wins over timeout
    stream.delete();
    repeat (TO - 1) stream.push_back(8'hFF);
    stream.push_back(8'hFE);
    push_block_with_crc();
    run_read(-1, -1);
    check("late_token_timeout", -1, 32'(bus.timeout), 32'd0);
    check("late_token_nvalid", -1, 32'(obs_nvalid), 32'd9);

    // Abort after two data bytes
    stream = '{8'hFF, 8'hFE};
    push_block_with_crc();
    run_read(33, -1);
    check("abort_nvalid", -1, 32'(obs_nvalid), 32'd2);
    check("abort_no_done", -1, 32'(obs_first_done), 32'hFFFF_FFFF);

    // Async reset in the CRC phase, then a clean read
    stream = '{8'hFF, 8'hFF, 8'hFF, 8'hFE};
    push_block_with_crc();
    run_read(-1, 115);
    run_read(-1, -1);
    check("post_reset_nvalid", -1, 32'(obs_nvalid), 32'd9);

    // Randomized reads
    for (int r = 0; r < 25; r++) begin
      r_kind = $urandom_range(0, 9);
      r_slots = $urandom_range(0, TO - 1);
      stream.delete();
      repeat (r_slots) stream.push_back(8'hFF);
      case (r_kind)
        0: ;
        1: stream.push_back(8'($urandom_range(1, 15)));
        2: stream.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(16, 253)));
        default: begin
          stream.push_back(8'hFE);
          rdata.delete();
          for (int j = 0; j < BB; j++) rdata.push_back(8'($urandom_range(0, 255)));
          foreach (rdata[i]) stream.push_back(rdata[i]);
          r_crc = crc_model(rdata);
          if ($urandom_range(0, 3) == 0) r_crc ^= 16'(1 << $urandom_range(0, 15));
          stream.push_back(r_crc[15:8]);
          stream.push_back(r_crc[7:0]);
        end
      endcase
      build_model(-1);
      r_ab = -1;
      if ($urandom_range(0, 4) == 0) r_ab = $urandom_range(1, end_c - 1);
      run_read(r_ab, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
